// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Purpose:
//   Operand bypass and load-use hazard unit for an in-order pipeline.
//   The unit keeps a shadow copy of the destination-register information for
//   every stage after ID (stage 1 = EX ... stage DEPTH = WB). For each source
//   operand of the ID instruction it picks the youngest matching producer and
//   reports its stage as the forward select. If that producer is a load that
//   has not yet reached LOAD_READY, it raises stall. A saturating counter
//   records how many cycles stall was high.
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   id_valid     in   ID holds a real instruction
//   id_src_addr  in   source register addresses; operand s at [s*ADDR_W +: ADDR_W]
//   id_src_used  in   per-operand read enable
//   id_dst_addr  in   destination register of the ID instruction
//   id_reg_write in   ID instruction writes a register
//   id_is_load   in   ID instruction is a load
//   flush        in   squash of ID and EX
//   fwd_sel      out  per operand: 0 = register file, k = forward from stage k
//   stall        out  hold PC and IF/ID, inject a bubble into EX
//   stall_count  out  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(DEPTH + 1),
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [ADDR_W-1:0]         id_dst_addr,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_count
);

  // Shadow pipeline, index k = stage number (1 = EX).
  logic [DEPTH:1]    vld_q, vld_d;
  logic [DEPTH:1]    wr_q,  wr_d;
  logic [DEPTH:1]    ld_q,  ld_d;
  logic [ADDR_W-1:0] dst_q [1:DEPTH];
  logic [ADDR_W-1:0] dst_d [1:DEPTH];

  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  logic [SEL_W-1:0]  sel;
  logic              hit_ld;
  logic              load_use;

  // Operand select and load-use detection. Stages are scanned oldest to
  // youngest so the last match written (the smallest k) wins; hit_ld then
  // reflects only that youngest producer, letting a younger ALU result mask
  // an older load to the same register.
  always_comb begin
    fwd_sel  = '0;
    sel      = '0;
    hit_ld   = 1'b0;
    load_use = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      sel    = '0;
      hit_ld = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (id_src_used[s] && vld_q[k] && wr_q[k] &&
            (dst_q[k] != '0) &&
            (dst_q[k] == id_src_addr[s*ADDR_W +: ADDR_W])) begin
          sel    = SEL_W'(k);
          hit_ld = ld_q[k] && (k < LOAD_READY);
        end
      end
      fwd_sel[s*SEL_W +: SEL_W] = sel;
      if (hit_ld) begin
        load_use = 1'b1;
      end
    end
  end

  assign stall = id_valid && !flush && load_use;

  // Next state: stages behind ID always advance; entry 1 takes a bubble
  // on flush or stall, otherwise the ID instruction.
  always_comb begin
    for (int k = 2; k <= DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      wr_d[k]  = wr_q[k-1];
      ld_d[k]  = ld_q[k-1];
      dst_d[k] = dst_q[k-1];
    end
    if (flush || stall) begin
      vld_d[1] = 1'b0;
      wr_d[1]  = 1'b0;
      ld_d[1]  = 1'b0;
      dst_d[1] = '0;
    end else begin
      vld_d[1] = id_valid;
      wr_d[1]  = id_reg_write;
      ld_d[1]  = id_is_load;
      dst_d[1] = id_dst_addr;
    end

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      wr_q          <= '0;
      ld_q          <= '0;
      stall_count_q <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= '0;
      end
    end else begin
      vld_q         <= vld_d;
      wr_q          <= wr_d;
      ld_q          <= ld_d;
      stall_count_q <= stall_count_d;
      for (int k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= dst_d[k];
      end
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int ADDR_W = 5;
  localparam int NUM_SRC = 2;
  localparam int SEL_W = 2;

  logic                      clk;
  logic                      rst;
  logic                      id_valid;
  logic [NUM_SRC*ADDR_W-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [ADDR_W-1:0]         id_dst_addr;
  logic                      id_reg_write;
  logic                      id_is_load;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel, fwd_sel_s;
  logic                      stall, stall_s;
  logic [31:0]               stall_count;
  logic [3:0]                stall_count_s;

  int n_checks = 0;
  int n_errors = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst_addr(id_dst_addr),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel(fwd_sel_s), .stall(stall_s), .stall_count(stall_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ID drive: valid, src1, src0, used, dst, reg_write, is_load, flush
  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                       input logic [1:0] used, input logic [4:0] dst,
                       input logic wr, input logic ld, input logic fl);
    id_valid     = v;
    id_src_addr  = {s1, s0};
    id_src_used  = used;
    id_dst_addr  = dst;
    id_reg_write = wr;
    id_is_load   = ld;
    flush        = fl;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with a matching instruction sitting in ID
    rst = 1'b1;
    drive(1, 3, 3, 2'b11, 3, 1, 1, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("reset_fwd", 32'(fwd_sel), 32'h0);
    check_eq("reset_stall", 32'(stall), 32'h0);
    check_eq("reset_cnt", stall_count, 32'h0);

    // ALU chain: add r3 then readers at increasing distance
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0);
    tick();
    drive(1, 4, 3, 2'b11, 0, 0, 0, 0);
    check_eq("alu_ex", 32'(fwd_sel), 32'h1);
    check_eq("alu_ex_stall", 32'(stall), 32'h0);
    nop();
    tick();
    drive(1, 4, 3, 2'b11, 0, 0, 0, 0);
    check_eq("alu_mem", 32'(fwd_sel), 32'h2);
    nop();
    tick();
    drive(1, 3, 3, 2'b11, 0, 0, 0, 0);
    check_eq("alu_wb", 32'(fwd_sel), 32'hF);
    nop();
    tick();
    drive(1, 3, 3, 2'b11, 0, 0, 0, 0);
    check_eq("alu_retired", 32'(fwd_sel), 32'h0);

    // Priority: r5 in both EX and MEM, youngest wins
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0);
    tick();
    drive(1, 5, 5, 2'b11, 0, 0, 0, 0);
    check_eq("prio_ex", 32'(fwd_sel), 32'h5);
    // EX now writes r0, which must not forward
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 0, 1, 0, 0);
    tick();
    drive(1, 5, 5, 2'b11, 0, 0, 0, 0);
    check_eq("prio_r0", 32'(fwd_sel), 32'hA);

    // Load-use: lw r7, then reader of r7 on src1 (also writes r8)
    nop(); tick(); tick(); tick();
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0);
    tick();
    drive(1, 7, 8, 2'b11, 8, 1, 0, 0);
    check_eq("lu_stall", 32'(stall), 32'h1);
    check_eq("lu_stall_fwd", 32'(fwd_sel), 32'h4);
    tick();
    // Entry 1 must be a bubble, so r8 must not show up as a producer
    check_eq("lu_release", 32'(stall), 32'h0);
    check_eq("lu_release_fwd", 32'(fwd_sel), 32'h8);
    check_eq("lu_cnt", stall_count, 32'h1);
    check_eq("lu_cnt_sat", 32'(stall_count_s), 32'h1);

    // Unused operand and invalid ID never stall
    nop(); tick(); tick(); tick();
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0);
    tick();
    drive(1, 7, 0, 2'b01, 0, 0, 0, 0);
    check_eq("unused_stall", 32'(stall), 32'h0);
    check_eq("unused_fwd", 32'(fwd_sel), 32'h0);
    drive(0, 7, 0, 2'b10, 0, 0, 0, 0);
    check_eq("invalid_stall", 32'(stall), 32'h0);

    // Flush: lw squashed in ID never becomes a producer
    nop(); tick(); tick(); tick();
    drive(1, 0, 0, 2'b00, 7, 1, 1, 1);
    tick();
    drive(1, 7, 0, 2'b10, 0, 0, 0, 0);
    check_eq("flush_stall", 32'(stall), 32'h0);
    check_eq("flush_fwd", 32'(fwd_sel), 32'h0);
    // Stall condition coinciding with flush is suppressed
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0);
    tick();
    drive(1, 7, 0, 2'b10, 0, 0, 0, 1);
    check_eq("flush_vs_stall", 32'(stall), 32'h0);
    check_eq("flush_vs_stall_fwd", 32'(fwd_sel), 32'h4);
    tick();
    check_eq("flush_cnt", stall_count, 32'h1);

    // Saturation: back-to-back lw r7 reading r7 stalls every other cycle
    nop(); tick(); tick(); tick();
    drive(1, 7, 0, 2'b10, 7, 1, 1, 0);
    for (int i = 0; i < 40; i++) tick();
    check_eq("sat_cnt4", 32'(stall_count_s), 32'hF);
    check_eq("sat_cnt32", stall_count, 32'd21);
    tick();
    check_eq("sat_stall_hi", 32'(stall), 32'h1);
    tick();
    check_eq("sat_hold", 32'(stall_count_s), 32'hF);
    check_eq("sat_cnt32_b", stall_count, 32'd22);
    nop(); tick(); tick();
    check_eq("sat_hold_idle", 32'(stall_count_s), 32'hF);

    // Mid-operation reset forgets in-flight producers
    drive(1, 0, 0, 2'b00, 3, 1, 0, 0);
    tick();
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    drive(1, 3, 3, 2'b11, 0, 0, 0, 0);
    check_eq("midrst_fwd", 32'(fwd_sel), 32'h0);
    check_eq("midrst_cnt", stall_count, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
